// File: rtl/placement_cost_eval_if.sv
// Handshake and memory-port bundle for the placement wirelength evaluator.
// The slave modport is the evaluator side; the master modport drives run control and memory read data.
interface placement_cost_eval_if #(
  parameter int EDGE_AW = 5,
  parameter int NODE_AW = 7,
  parameter int COORD_W = 32,
  parameter int SUM_W   = 32
);
  logic                start;
  logic [1:0]          mode;
  logic                edge_re;
  logic [EDGE_AW-1:0]  edge_addr;
  logic [NODE_AW-1:0]  edge_a;
  logic [NODE_AW-1:0]  edge_b;
  logic                pos_re;
  logic [NODE_AW-1:0]  pos_addr;
  logic [COORD_W-1:0]  pos_x;
  logic [COORD_W-1:0]  pos_y;
  logic                busy;
  logic                done;
  logic [SUM_W-1:0]    cost;
  logic [SUM_W-1:0]    max_cost;
  logic                unplaced;

  modport slave (
    input  start, mode, edge_a, edge_b, pos_x, pos_y,
    output edge_re, edge_addr, pos_re, pos_addr, busy, done, cost, max_cost, unplaced
  );

  modport master (
    output start, mode, edge_a, edge_b, pos_x, pos_y,
    input  edge_re, edge_addr, pos_re, pos_addr, busy, done, cost, max_cost, unplaced
  );
endinterface

// File: rtl/placement_cost_eval.sv
// Walks the edge list, fetches endpoint coordinates and accumulates a saturating wirelength cost.
// 6 cycles per edge, done pulses 6*N_EDGE cycles after start; start/mode ignored while busy.
module placement_cost_eval #(
  parameter int N_EDGE  = 22,
  parameter int EDGE_AW = 5,
  parameter int NODE_AW = 7,
  parameter int COORD_W = 32,
  parameter int SUM_W   = 32
) (
  input  logic clk,
  input  logic reset,
  placement_cost_eval_if.slave bus
);

  localparam int EW = (COORD_W + 3 > SUM_W + 1) ? COORD_W + 3 : SUM_W + 1;
  localparam logic [EW-1:0] E_SAT = EW'({SUM_W{1'b1}});
  localparam logic [EDGE_AW-1:0] LAST_EDGE = EDGE_AW'(N_EDGE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EDGE, S_EA, S_PA, S_PB, S_DIFF, S_ACC, S_DONE
  } state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [EDGE_AW-1:0]  r_i;
  logic [NODE_AW-1:0]  r_b;
  logic [COORD_W-1:0]  r_ax, r_ay, r_bx, r_by;
  logic [COORD_W:0]    r_dx, r_dy;
  logic                r_skip;
  logic [SUM_W-1:0]    r_cost, r_max;
  logic                r_unplaced, r_busy, r_done, r_edge_re;
  logic [EDGE_AW-1:0]  r_edge_addr;

  logic signed [COORD_W:0] w_ddx, w_ddy;
  logic [COORD_W:0]    w_adx, w_ady;
  logic [EW-1:0]       w_dx, w_dy, w_hx, w_hy, w_raw, w_e;
  logic [SUM_W-1:0]    w_e_sat, w_cost_nxt;
  logic [SUM_W:0]      w_sum;
  logic                w_skip;

  // Differences are taken one bit wider so extreme coordinates cannot overflow.
  assign w_ddx = {r_ax[COORD_W-1], r_ax} - {r_bx[COORD_W-1], r_bx};
  assign w_ddy = {r_ay[COORD_W-1], r_ay} - {r_by[COORD_W-1], r_by};
  assign w_adx = w_ddx[COORD_W] ? -w_ddx : w_ddx;
  assign w_ady = w_ddy[COORD_W] ? -w_ddy : w_ddy;
  assign w_skip = (r_ax == {COORD_W{1'b1}}) || (r_ay == {COORD_W{1'b1}}) ||
                  (r_bx == {COORD_W{1'b1}}) || (r_by == {COORD_W{1'b1}});

  assign w_dx = EW'(r_dx);
  assign w_dy = EW'(r_dy);
  assign w_hx = (w_dx >> 1) + (w_dx & EW'(1));
  assign w_hy = (w_dy >> 1) + (w_dy & EW'(1));

  always_comb begin
    case (r_mode)
      2'd1:    w_raw = (w_dx > w_dy) ? w_dx : w_dy;
      2'd2:    w_raw = w_hx + w_hy;
      default: w_raw = w_dx + w_dy;
    endcase
  end

  // Coincident endpoints give a raw cost of zero; clamp rather than underflow.
  assign w_e        = (w_raw == '0) ? '0 : w_raw - EW'(1);
  assign w_e_sat    = (w_e > E_SAT) ? {SUM_W{1'b1}} : w_e[SUM_W-1:0];
  assign w_sum      = {1'b0, r_cost} + {1'b0, w_e_sat};
  assign w_cost_nxt = w_sum[SUM_W] ? {SUM_W{1'b1}} : w_sum[SUM_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'd0;
      r_i         <= '0;
      r_b         <= '0;
      r_ax        <= '0;
      r_ay        <= '0;
      r_bx        <= '0;
      r_by        <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_skip      <= 1'b0;
      r_cost      <= '0;
      r_max       <= '0;
      r_unplaced  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_edge_re   <= 1'b0;
      r_edge_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state     <= S_EDGE;
          r_mode      <= bus.mode;
          r_cost      <= '0;
          r_max       <= '0;
          r_unplaced  <= 1'b0;
          r_i         <= '0;
          r_busy      <= 1'b1;
          r_edge_re   <= 1'b1;
          r_edge_addr <= '0;
        end
        S_EDGE: begin
          r_edge_re <= 1'b0;
          r_state   <= S_EA;
        end
        S_EA: begin
          r_b     <= bus.edge_b;
          r_state <= S_PA;
        end
        S_PA: begin
          r_ax    <= bus.pos_x;
          r_ay    <= bus.pos_y;
          r_state <= S_PB;
        end
        S_PB: begin
          r_bx    <= bus.pos_x;
          r_by    <= bus.pos_y;
          r_state <= S_DIFF;
        end
        S_DIFF: begin
          r_dx    <= w_adx;
          r_dy    <= w_ady;
          r_skip  <= w_skip;
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (r_skip) begin
            r_unplaced <= 1'b1;
          end else begin
            r_cost <= w_cost_nxt;
            if (w_e_sat > r_max) r_max <= w_e_sat;
          end
          if (r_i == LAST_EDGE) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i         <= r_i + 1'b1;
            r_edge_re   <= 1'b1;
            r_edge_addr <= r_i + 1'b1;
            r_state     <= S_EDGE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Source id arrives from the edge ROM in S_EA itself, so its address is forwarded directly.
  assign bus.pos_re    = (r_state == S_EA) || (r_state == S_PA);
  assign bus.pos_addr  = (r_state == S_EA) ? bus.edge_a :
                         (r_state == S_PA) ? r_b : '0;
  assign bus.edge_re   = r_edge_re;
  assign bus.edge_addr = r_edge_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cost      = r_cost;
  assign bus.max_cost  = r_max;
  assign bus.unplaced  = r_unplaced;

endmodule

// File: tb/tb_placement_cost_eval.sv
// Directed bench for placement_cost_eval: a 3-edge instance with 32-bit sums and a 4-bit-sum instance
// for saturation, each backed by 1-cycle-latency edge and position memory models.
module tb_placement_cost_eval;

  logic clk;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int   bad_addr = 0;

  placement_cost_eval_if #(.EDGE_AW(5), .NODE_AW(7), .COORD_W(32), .SUM_W(32)) bus_a ();
  placement_cost_eval_if #(.EDGE_AW(5), .NODE_AW(7), .COORD_W(32), .SUM_W(4))  bus_s ();

  placement_cost_eval #(.N_EDGE(3), .EDGE_AW(5), .NODE_AW(7), .COORD_W(32), .SUM_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  placement_cost_eval #(.N_EDGE(3), .EDGE_AW(5), .NODE_AW(7), .COORD_W(32), .SUM_W(4)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  logic [6:0]  ea_a [0:31];
  logic [6:0]  eb_a [0:31];
  logic [31:0] px_a [0:127];
  logic [31:0] py_a [0:127];
  logic [6:0]  ea_s [0:31];
  logic [6:0]  eb_s [0:31];
  logic [31:0] px_s [0:127];
  logic [31:0] py_s [0:127];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_a.edge_re) begin
      bus_a.edge_a <= ea_a[bus_a.edge_addr];
      bus_a.edge_b <= eb_a[bus_a.edge_addr];
    end
    if (bus_a.pos_re) begin
      bus_a.pos_x <= px_a[bus_a.pos_addr];
      bus_a.pos_y <= py_a[bus_a.pos_addr];
    end
    if (bus_s.edge_re) begin
      bus_s.edge_a <= ea_s[bus_s.edge_addr];
      bus_s.edge_b <= eb_s[bus_s.edge_addr];
    end
    if (bus_s.pos_re) begin
      bus_s.pos_x <= px_s[bus_s.pos_addr];
      bus_s.pos_y <= py_s[bus_s.pos_addr];
    end
    if (bus_a.edge_re === 1'b1 && bus_a.edge_addr > 5'd2) bad_addr <= bad_addr + 1;
  end

  task automatic load_base();
    for (int n = 0; n < 128; n++) begin
      px_a[n] = 32'd0; py_a[n] = 32'd0; px_s[n] = 32'd0; py_s[n] = 32'd0;
    end
    for (int n = 0; n < 32; n++) begin
      ea_a[n] = 7'd0; eb_a[n] = 7'd0; ea_s[n] = 7'd0; eb_s[n] = 7'd1;
    end
    px_a[1] = 32'd3; py_a[1] = 32'd1;
    px_a[2] = 32'd2; py_a[2] = 32'd4;
    ea_a[0] = 7'd0; eb_a[0] = 7'd1;
    ea_a[1] = 7'd1; eb_a[1] = 7'd2;
    ea_a[2] = 7'd0; eb_a[2] = 7'd2;
    px_s[1] = 32'd9; py_s[1] = 32'd9;
  endtask

  task automatic run_a(input logic [1:0] m, output int lat);
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.mode  = m;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_a.mode  = m ^ 2'b01;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus_a.done === 1'b1) begin lat = n; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_s(input logic [1:0] m, output int lat);
    @(negedge clk);
    bus_s.start = 1'b1;
    bus_s.mode  = m;
    @(posedge clk); #1;
    bus_s.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus_s.done === 1'b1) begin lat = n; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_a.start = 1'b0; bus_a.mode = 2'd0;
    bus_s.start = 1'b0; bus_s.mode = 2'd0;
    load_base();
    #12;
    checks++; if (bus_a.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus_a.busy); else passed++;
    checks++; if (bus_a.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus_a.done); else passed++;
    checks++; if (bus_a.edge_re !== 1'b0) $display("FAIL reset_edge_re: got %b expected 0", bus_a.edge_re); else passed++;
    checks++; if (bus_a.pos_re !== 1'b0) $display("FAIL reset_pos_re: got %b expected 0", bus_a.pos_re); else passed++;
    checks++; if (bus_a.edge_addr !== 5'd0) $display("FAIL reset_edge_addr: got %0d expected 0", bus_a.edge_addr); else passed++;
    checks++; if (bus_a.pos_addr !== 7'd0) $display("FAIL reset_pos_addr: got %0d expected 0", bus_a.pos_addr); else passed++;
    checks++; if (bus_a.cost !== 32'd0) $display("FAIL reset_cost: got %0d expected 0", bus_a.cost); else passed++;
    checks++; if (bus_a.max_cost !== 32'd0) $display("FAIL reset_max_cost: got %0d expected 0", bus_a.max_cost); else passed++;
    checks++; if (bus_a.unplaced !== 1'b0) $display("FAIL reset_unplaced: got %b expected 0", bus_a.unplaced); else passed++;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_manhattan();
    int lat;
    run_a(2'd0, lat);
    checks++; if (lat !== 18) $display("FAIL manh_latency: got %0d expected 18", lat); else passed++;
    checks++; if (bus_a.cost !== 32'd11) $display("FAIL manh_cost: got %0d expected 11", bus_a.cost); else passed++;
    checks++; if (bus_a.max_cost !== 32'd5) $display("FAIL manh_max: got %0d expected 5", bus_a.max_cost); else passed++;
    checks++; if (bus_a.unplaced !== 1'b0) $display("FAIL manh_unplaced: got %b expected 0", bus_a.unplaced); else passed++;
    checks++; if (bus_a.busy !== 1'b0) $display("FAIL manh_idle_busy: got %b expected 0", bus_a.busy); else passed++;
    repeat (4) @(posedge clk); #1;
    checks++; if (bus_a.cost !== 32'd11) $display("FAIL manh_cost_hold: got %0d expected 11", bus_a.cost); else passed++;
  endtask

  task automatic test_chebyshev();
    int lat;
    run_a(2'd1, lat);
    checks++; if (lat !== 18) $display("FAIL cheb_latency: got %0d expected 18", lat); else passed++;
    checks++; if (bus_a.cost !== 32'd7) $display("FAIL cheb_cost: got %0d expected 7", bus_a.cost); else passed++;
    checks++; if (bus_a.max_cost !== 32'd3) $display("FAIL cheb_max: got %0d expected 3", bus_a.max_cost); else passed++;
  endtask

  task automatic test_one_hop();
    int lat;
    run_a(2'd2, lat);
    checks++; if (bus_a.cost !== 32'd6) $display("FAIL hop_cost: got %0d expected 6", bus_a.cost); else passed++;
    checks++; if (bus_a.max_cost !== 32'd2) $display("FAIL hop_max: got %0d expected 2", bus_a.max_cost); else passed++;
    run_a(2'd3, lat);
    checks++; if (bus_a.cost !== 32'd11) $display("FAIL reserved_mode_cost: got %0d expected 11", bus_a.cost); else passed++;
  endtask

  task automatic test_unplaced();
    int lat;
    px_a[2] = 32'hFFFF_FFFF;
    run_a(2'd0, lat);
    checks++; if (lat !== 18) $display("FAIL unpl_latency: got %0d expected 18", lat); else passed++;
    checks++; if (bus_a.unplaced !== 1'b1) $display("FAIL unpl_flag: got %b expected 1", bus_a.unplaced); else passed++;
    checks++; if (bus_a.cost !== 32'd3) $display("FAIL unpl_cost: got %0d expected 3", bus_a.cost); else passed++;
    checks++; if (bus_a.max_cost !== 32'd3) $display("FAIL unpl_max: got %0d expected 3", bus_a.max_cost); else passed++;
    px_a[2] = 32'd2;
  endtask

  task automatic test_coincident();
    int lat;
    ea_a[0] = 7'd0; eb_a[0] = 7'd0;
    ea_a[1] = 7'd0; eb_a[1] = 7'd1;
    ea_a[2] = 7'd1; eb_a[2] = 7'd1;
    run_a(2'd0, lat);
    checks++; if (bus_a.cost !== 32'd3) $display("FAIL coinc_manh_cost: got %0d expected 3", bus_a.cost); else passed++;
    checks++; if (bus_a.max_cost !== 32'd3) $display("FAIL coinc_manh_max: got %0d expected 3", bus_a.max_cost); else passed++;
    checks++; if (bus_a.unplaced !== 1'b0) $display("FAIL coinc_unplaced: got %b expected 0", bus_a.unplaced); else passed++;
    run_a(2'd1, lat);
    checks++; if (bus_a.cost !== 32'd2) $display("FAIL coinc_cheb_cost: got %0d expected 2", bus_a.cost); else passed++;
    load_base();
  endtask

  task automatic test_saturation();
    int lat;
    run_s(2'd1, lat);
    checks++; if (lat !== 18) $display("FAIL sat_latency: got %0d expected 18", lat); else passed++;
    checks++; if (bus_s.cost !== 4'd15) $display("FAIL sat_cheb_cost: got %0d expected 15", bus_s.cost); else passed++;
    checks++; if (bus_s.max_cost !== 4'd8) $display("FAIL sat_cheb_max: got %0d expected 8", bus_s.max_cost); else passed++;
    run_s(2'd2, lat);
    checks++; if (bus_s.cost !== 4'd15) $display("FAIL sat_hop_cost: got %0d expected 15", bus_s.cost); else passed++;
    checks++; if (bus_s.max_cost !== 4'd9) $display("FAIL sat_hop_max: got %0d expected 9", bus_s.max_cost); else passed++;
  endtask

  task automatic test_busy_restart();
    int first, ndone;
    first = -1; ndone = 0;
    @(negedge clk); bus_a.start = 1'b1; bus_a.mode = 2'd0;
    @(posedge clk); #1; bus_a.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin bus_a.start = 1'b1; bus_a.mode = 2'd1; end
      if (n == 6) bus_a.start = 1'b0;
      if (bus_a.done === 1'b1) begin
        ndone++;
        if (first < 0) first = n;
      end
    end
    checks++; if (ndone !== 1) $display("FAIL restart_done_count: got %0d expected 1", ndone); else passed++;
    checks++; if (first !== 18) $display("FAIL restart_latency: got %0d expected 18", first); else passed++;
    checks++; if (bus_a.cost !== 32'd11) $display("FAIL restart_cost: got %0d expected 11", bus_a.cost); else passed++;
  endtask

  task automatic test_reset_midrun();
    int lat, ndone;
    ndone = 0;
    @(negedge clk); bus_a.start = 1'b1; bus_a.mode = 2'd0;
    @(posedge clk); #1; bus_a.start = 1'b0;
    repeat (7) @(posedge clk);
    #2; reset = 1'b0; #1;
    checks++; if (bus_a.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus_a.busy); else passed++;
    checks++; if (bus_a.cost !== 32'd0) $display("FAIL midrst_cost: got %0d expected 0", bus_a.cost); else passed++;
    checks++; if (bus_a.max_cost !== 32'd0) $display("FAIL midrst_max: got %0d expected 0", bus_a.max_cost); else passed++;
    checks++; if (bus_a.edge_re !== 1'b0 || bus_a.pos_re !== 1'b0) $display("FAIL midrst_strobes: got %b%b expected 00", bus_a.edge_re, bus_a.pos_re); else passed++;
    checks++; if (bus_a.edge_addr !== 5'd0) $display("FAIL midrst_edge_addr: got %0d expected 0", bus_a.edge_addr); else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (bus_a.done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) $display("FAIL midrst_no_done: got %0d expected 0", ndone); else passed++;
    run_a(2'd0, lat);
    checks++; if (lat !== 18) $display("FAIL midrst_rerun_latency: got %0d expected 18", lat); else passed++;
    checks++; if (bus_a.cost !== 32'd11) $display("FAIL midrst_rerun_cost: got %0d expected 11", bus_a.cost); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    lat1 = -1; lat2 = -1;
    @(negedge clk); bus_a.start = 1'b1; bus_a.mode = 2'd1;
    @(posedge clk); #1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus_a.done === 1'b1) begin lat1 = n; break; end
    end
    @(posedge clk); #1;
    checks++; if (bus_a.busy !== 1'b0) $display("FAIL b2b_idle_gap: got %b expected 0", bus_a.busy); else passed++;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    checks++; if (bus_a.busy !== 1'b1) $display("FAIL b2b_retrigger: got %b expected 1", bus_a.busy); else passed++;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus_a.done === 1'b1) begin lat2 = n; break; end
    end
    checks++; if (lat1 !== 18 || lat2 !== 18) $display("FAIL b2b_latency: got %0d,%0d expected 18,18", lat1, lat2); else passed++;
    checks++; if (bus_a.cost !== 32'd7) $display("FAIL b2b_cost: got %0d expected 7", bus_a.cost); else passed++;
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_manhattan();
    test_chebyshev();
    test_one_hop();
    test_unplaced();
    test_coincident();
    test_saturation();
    test_busy_restart();
    test_reset_midrun();
    test_back_to_back();
    checks++; if (bad_addr !== 0) $display("FAIL edge_addr_range: got %0d out-of-range reads expected 0", bad_addr); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
